regfile_dump: RTL and testbench

Debug read-out engine for the pipelined CPU's register file. It is the reader counterpart to the register-file write port: on a start pulse it walks every architectural register through one asynchronous read port. Each sampled value is streamed out on a valid/ready interface toward the debug/trace path, so the full register state can be extracted without stalling the pipeline's own read ports.

---
 rtl/regfile_dump_if.sv | 27 ++
 rtl/regfile_dump.sv | 133 +++++++++++++
 tb/tb_regfile_dump.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_if.sv
// Handshake bundle between the register-file dump engine and its neighbours:
// the start/busy/done control, the asynchronous read port and the output stream.
interface regfile_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W:0]   out_index;
  logic              out_last;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, rd_addr, out_valid, out_data, out_index, out_last
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, rd_addr, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/regfile_dump.sv
// Walks every architectural register through one async read port and streams the values out.
// Optional REGDUMP_CHECKSUM_EN appends a modular-sum word after the last register.
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input logic            clk,
  input logic            reset,
  regfile_dump_if.master bus
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, CKSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SEND, DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic                done_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                out_valid_r;
  logic [DATA_W-1:0]   out_data_r;
  logic [ADDR_W:0]     out_index_r;
  logic                out_last_r;

`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [ADDR_W:0] CKSUM_INDEX = (ADDR_W + 1)'(NUM_REGS);

  logic [DATA_W-1:0]   sum_r;

  // Running checksum wraps modulo 2^DATA_W; carries out of the top bit are discarded.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = a + b;
    return s;
  endfunction
`endif

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.rd_addr   = rd_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_index = out_index_r;
  assign bus.out_last  = out_last_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      done_r      <= 1'b0;
      rd_addr_r   <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_index_r <= '0;
      out_last_r  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      sum_r       <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rd_addr_r <= '0;
`ifdef REGDUMP_CHECKSUM_EN
            sum_r     <= '0;
`endif
            state     <= FETCH;
          end
        end

        // Sample the read port for the current address; the value is frozen from here on.
        FETCH: begin
          out_data_r  <= bus.rd_data;
          out_index_r <= {1'b0, rd_addr_r};
          out_valid_r <= 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          sum_r       <= wrap_add(sum_r, bus.rd_data);
          out_last_r  <= 1'b0;
`else
          out_last_r  <= (rd_addr_r == LAST_ADDR);
`endif
          state       <= SEND;
        end

        SEND: begin
          if (bus.out_ready) begin
            if (rd_addr_r != LAST_ADDR) begin
              out_valid_r <= 1'b0;
              rd_addr_r   <= rd_addr_r + 1'b1;
              state       <= FETCH;
            end else begin
`ifdef REGDUMP_CHECKSUM_EN
              // Valid stays high: the checksum word follows the last register directly.
              out_data_r  <= sum_r;
              out_index_r <= CKSUM_INDEX;
              out_last_r  <= 1'b1;
              state       <= CKSUM;
`else
              out_valid_r <= 1'b0;
              done_r      <= 1'b1;
              state       <= DONE;
`endif
            end
          end
        end

`ifdef REGDUMP_CHECKSUM_EN
        CKSUM: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b1;
            state       <= DONE;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: reset, full dump timing, back-pressure, start while busy,
// reset mid-dump, and the checksum word when REGDUMP_CHECKSUM_EN is defined.
module tb_regfile_dump;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CK       = 1'b1;
  localparam int DONE_CYC = 65;
`else
  localparam bit CK       = 1'b0;
  localparam int DONE_CYC = 64;
`endif
  // 496 * 32'h01010101, bytes carry into each other: 0x1F0 per byte lane.
  localparam logic [31:0] SUM_EXP = 32'hF1F1F1F0;

  logic clk;
  logic reset;
  logic [31:0] regs [32];
  int checks = 0;
  int errors = 0;

  regfile_dump_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rd_data = regs[bus.rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.out_valid, bus.out_last} !== 4'b0 || bus.rd_addr !== 5'd0 ||
        bus.out_data !== 32'd0 || bus.out_index !== 6'd0) begin
      errors++;
      $display("FAIL reset_async: busy %b done %b valid %b last %b addr %h data %h idx %h, expected all 0",
               bus.busy, bus.done, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data, bus.out_index);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy %b valid %b done %b, expected 0 0 0", bus.busy, bus.out_valid, bus.done);
    end
  endtask

  task automatic test_full_dump();
    int k;
    logic exp_valid, exp_last;
    logic [31:0] exp_data;
    logic [5:0] exp_idx;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_fetch0: busy %b valid %b, expected 1 0", bus.busy, bus.out_valid);
    end
    for (int cyc = 1; cyc <= DONE_CYC + 1; cyc++) begin
      tick();
      k = (cyc - 1) / 2;
      exp_valid = (((cyc % 2) == 1) && k < 32) || (CK && cyc == 64);
      exp_data  = (CK && cyc == 64) ? SUM_EXP : 32'h01010101 * k;
      exp_idx   = (CK && cyc == 64) ? 6'd32 : 6'(k);
      exp_last  = CK ? (cyc == 64) : (k == 31);
      checks++;
      if (bus.out_valid !== exp_valid) begin
        errors++;
        $display("FAIL full_valid cyc %0d: got %b, expected %b", cyc, bus.out_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.out_data !== exp_data || bus.out_index !== exp_idx || bus.out_last !== exp_last) begin
          errors++;
          $display("FAIL full_word cyc %0d: data %h idx %0d last %b, expected %h %0d %b",
                   cyc, bus.out_data, bus.out_index, bus.out_last, exp_data, exp_idx, exp_last);
        end
      end
      checks++;
      if (bus.done !== (cyc == DONE_CYC) || bus.busy !== (cyc <= DONE_CYC)) begin
        errors++;
        $display("FAIL full_ctrl cyc %0d: done %b busy %b, expected %b %b",
                 cyc, bus.done, bus.busy, (cyc == DONE_CYC), (cyc <= DONE_CYC));
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_k, s, e;
    logic exp_valid;
    logic [31:0] exp_data;
    logic [5:0] exp_idx;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= DONE_CYC + 6; cyc++) begin
      tick();
      exp_k = -1;
      for (int k = 0; k < 32; k++) begin
        s = 1 + 2 * k + ((k > 7) ? 5 : 0);
        e = s + ((k == 7) ? 5 : 0);
        if (cyc >= s && cyc <= e) exp_k = k;
      end
      exp_valid = (exp_k >= 0) || (CK && cyc == 69);
      exp_data  = (CK && cyc == 69) ? SUM_EXP : 32'h01010101 * exp_k;
      exp_idx   = (CK && cyc == 69) ? 6'd32 : 6'(exp_k);
      checks++;
      if (bus.out_valid !== exp_valid) begin
        errors++;
        $display("FAIL bp_valid cyc %0d: got %b, expected %b", cyc, bus.out_valid, exp_valid);
      end
      if (exp_valid) begin
        checks++;
        if (bus.out_data !== exp_data || bus.out_index !== exp_idx) begin
          errors++;
          $display("FAIL bp_word cyc %0d: data %h idx %0d, expected %h %0d",
                   cyc, bus.out_data, bus.out_index, exp_data, exp_idx);
        end
      end
      checks++;
      if (bus.done !== (cyc == DONE_CYC + 5)) begin
        errors++;
        $display("FAIL bp_done cyc %0d: got %b, expected %b", cyc, bus.done, (cyc == DONE_CYC + 5));
      end
      bus.out_ready = !(cyc >= 15 && cyc <= 19);
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic test_start_while_busy();
    int words = 0;
    int dones = 0;
    int last_idx = -1;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= DONE_CYC + 8; cyc++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        words++;
        checks++;
        if (int'(bus.out_index) !== last_idx + 1) begin
          errors++;
          $display("FAIL busy_order cyc %0d: idx %0d, expected %0d", cyc, bus.out_index, last_idx + 1);
        end
        last_idx = int'(bus.out_index);
      end
      if (bus.done === 1'b1) dones++;
      bus.start = (cyc == 21);
    end
    bus.start = 1'b0;
    checks++;
    if (words !== 32 + int'(CK) || dones !== 1) begin
      errors++;
      $display("FAIL busy_count: words %0d dones %0d, expected %0d 1", words, dones, 32 + int'(CK));
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_end: busy %b, expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid_dump();
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 25; cyc++) tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 6'd12 || bus.out_data !== 32'h0C0C0C0C) begin
      errors++;
      $display("FAIL rstmid_word12: valid %b idx %0d data %h, expected 1 12 0c0c0c0c",
               bus.out_valid, bus.out_index, bus.out_data);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.out_valid, bus.out_last} !== 4'b0 || bus.rd_addr !== 5'd0 ||
        bus.out_data !== 32'd0 || bus.out_index !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_async: busy %b done %b valid %b last %b addr %h data %h idx %h, expected all 0",
               bus.busy, bus.done, bus.out_valid, bus.out_last, bus.rd_addr, bus.out_data, bus.out_index);
    end
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: busy %b done %b valid %b, expected 0 0 0", bus.busy, bus.done, bus.out_valid);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_index !== 6'd0 || bus.out_data !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_restart: valid %b idx %0d data %h, expected 1 0 0",
               bus.out_valid, bus.out_index, bus.out_data);
    end
    for (int cyc = 2; cyc <= DONE_CYC + 2; cyc++) tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_finish: busy %b, expected 0", bus.busy);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
    regs[0] = 32'd0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
